// File: rtl/arm_ctrl_pkg.sv
// Shared encodings for the multicycle ARM control unit:
// FSM states, ALU/mux codes, data-processing commands and condition codes.
package arm_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd10
    } state_t;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    // Unsupported commands still run through the ALU as ADD.
    function automatic logic [1:0] alu_decode(input logic [3:0] cmd);
        logic [1:0] a;
        a = ALU_ADD;
        case (cmd)
            CMD_ADD: a = ALU_ADD;
            CMD_SUB: a = ALU_SUB;
            CMD_AND: a = ALU_AND;
            CMD_ORR: a = ALU_ORR;
            CMD_CMP: a = ALU_SUB;
            default: a = ALU_ADD;
        endcase
        return a;
    endfunction

    function automatic logic cmd_writes(input logic [3:0] cmd);
        return (cmd == CMD_ADD) || (cmd == CMD_SUB) ||
               (cmd == CMD_AND) || (cmd == CMD_ORR);
    endfunction

endpackage

// File: rtl/cond_check.sv
// ARM condition-code evaluation against stored NZCV flags.
// Purely combinational; shared with the pipelined core.
module cond_check
    import arm_ctrl_pkg::*;
(
    input  logic [3:0] Cond,
    input  logic [3:0] Flags,
    output logic       CondEx
);

    logic n, z, c, v;

    assign {n, z, c, v} = Flags;

    always_comb begin
        CondEx = 1'b1;
        case (Cond)
            COND_EQ: CondEx = z;
            COND_NE: CondEx = ~z;
            COND_CS: CondEx = c;
            COND_CC: CondEx = ~c;
            COND_MI: CondEx = n;
            COND_PL: CondEx = ~n;
            COND_VS: CondEx = v;
            COND_VC: CondEx = ~v;
            COND_HI: CondEx = c & ~z;
            COND_LS: CondEx = ~c | z;
            COND_GE: CondEx = (n == v);
            COND_LT: CondEx = (n != v);
            COND_GT: CondEx = ~z & (n == v);
            COND_LE: CondEx = z | (n != v);
            COND_AL: CondEx = 1'b1;
            COND_NV: CondEx = 1'b1;
            default: CondEx = 1'b1;
        endcase
    end

endmodule

// File: rtl/arm_mc_controller.sv
// Multicycle ARM control FSM with NZCV flag register.
// Define MEM_READY_EN to add a mem_ready stall input for memory states.
module arm_mc_controller
    import arm_ctrl_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [3:0]         Cond,
    input  logic [1:0]         Op,
    input  logic [5:0]         Funct,
    input  logic [3:0]         Rd,
    input  logic [3:0]         ALUFlags,
`ifdef MEM_READY_EN
    input  logic               mem_ready,
`endif
    output logic               PCWrite,
    output logic               AdrSrc,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic [1:0]         ResultSrc,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ALUControl,
    output logic [1:0]         ImmSrc,
    output logic [1:0]         RegSrc,
    output logic               RegWrite,
    output logic [STATE_W-1:0] state_o
);

    state_t     state;
    logic [3:0] flags;
    logic       condex;
    logic       rdy;
    logic [3:0] cmd;
    logic [1:0] dp_alu;
    logic       is_exec;
    logic       flag_upd;
    logic       rd_pc;
    logic       pc_w, ir_w, mem_w, reg_w;

`ifdef MEM_READY_EN
    assign rdy = mem_ready;
`else
    assign rdy = 1'b1;
`endif

    assign cmd      = Funct[4:1];
    assign dp_alu   = alu_decode(cmd);
    assign is_exec  = (state == S_EXECR) || (state == S_EXECI);
    assign flag_upd = is_exec && (Funct[0] || (cmd == CMD_CMP));
    assign rd_pc    = (Rd == 4'hF);

    cond_check u_cond (
        .Cond   (Cond),
        .Flags  (flags),
        .CondEx (condex)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_FETCH;
            flags <= 4'b0000;
        end else begin
            if (flag_upd) begin
                flags[3:2] <= ALUFlags[3:2];
                if (dp_alu == ALU_ADD || dp_alu == ALU_SUB)
                    flags[1:0] <= ALUFlags[1:0];
            end
            case (state)
                S_FETCH:
                    if (rdy) state <= S_DECODE;
                S_DECODE: begin
                    if (!condex)
                        state <= S_FETCH;
                    else begin
                        case (Op)
                            OP_MEM:  state <= S_MEMADR;
                            OP_DP:   state <= Funct[5] ? S_EXECI : S_EXECR;
                            OP_BR:   state <= S_BRANCH;
                            default: state <= S_FETCH;
                        endcase
                    end
                end
                S_MEMADR:
                    state <= Funct[0] ? S_MEMREAD : S_MEMWRITE;
                S_MEMREAD:
                    if (rdy) state <= S_MEMWB;
                S_MEMWRITE:
                    if (rdy) state <= S_FETCH;
                S_EXECR, S_EXECI:
                    state <= cmd_writes(cmd) ? S_ALUWB : S_FETCH;
                default:
                    state <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        pc_w       = 1'b0;
        ir_w       = 1'b0;
        mem_w      = 1'b0;
        reg_w      = 1'b0;
        AdrSrc     = 1'b0;
        ResultSrc  = RES_ALUOUT;
        ALUSrcA    = 1'b0;
        ALUSrcB    = SRCB_RD2;
        ALUControl = ALU_ADD;
        RegSrc     = 2'b00;
        case (state)
            S_FETCH: begin
                ir_w      = rdy;
                pc_w      = rdy;
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
            end
            S_DECODE: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_FOUR;
            end
            S_MEMADR: begin
                ALUSrcB = SRCB_IMM;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                reg_w     = ~rd_pc;
                pc_w      = rd_pc;
            end
            S_MEMWRITE: begin
                AdrSrc = 1'b1;
                mem_w  = 1'b1;
                RegSrc = 2'b10;
            end
            S_EXECR: begin
                ALUControl = dp_alu;
            end
            S_EXECI: begin
                ALUSrcB    = SRCB_IMM;
                ALUControl = dp_alu;
            end
            S_ALUWB: begin
                reg_w = ~rd_pc;
                pc_w  = rd_pc;
            end
            S_BRANCH: begin
                RegSrc    = 2'b01;
                ALUSrcB   = SRCB_IMM;
                ResultSrc = RES_ALURESULT;
                pc_w      = 1'b1;
            end
            default: begin
                pc_w = 1'b0;
            end
        endcase
    end

    // Write enables are killed combinationally so reset aborts at once.
    assign PCWrite  = pc_w & ~reset;
    assign IRWrite  = ir_w & ~reset;
    assign MemWrite = mem_w & ~reset;
    assign RegWrite = reg_w & ~reset;
    assign ImmSrc   = Op;
    assign state_o  = STATE_W'(state);

endmodule
